datapath_multi: RTL and testbench

DATAPATH_MULTI -- requirements
Module: datapath_multi

---
 rtl/datapath_multi.sv | 184 ++++++++++++++++++
 tb/tb_datapath_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_multi.sv
// rtl/datapath_multi.sv - multi-accumulator datapath with ALU and iterative shift-add multiplier
module datapath_multi #(
    parameter int E_BITS  = 16,
    parameter int D_BITS  = 11,
    parameter int S_BITS  = 2,
    parameter int N_ACC   = 4,
    parameter int OP_BITS = 3
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [D_BITS-1:0]        i_Data,
    input  logic [E_BITS-1:0]        i_Data_ram,
    input  logic [S_BITS-1:0]        sel_A,
    input  logic                     sel_B,
    input  logic [OP_BITS-1:0]       i_op,
    input  logic                     w_acc,
    input  logic [$clog2(N_ACC)-1:0] i_acc_sel,
    output logic [D_BITS-1:0]        o_Addr_ram,
    output logic [E_BITS-1:0]        o_Data_ram,
    output logic [3:0]               o_flags,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int AW   = $clog2(N_ACC);
    localparam int SH_W = $clog2(E_BITS);
    localparam int CW   = $clog2(E_BITS + 1);
    localparam int MSB  = E_BITS - 1;

    localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] OP_SHL = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] OP_SRA = OP_BITS'(6);
    localparam logic [OP_BITS-1:0] OP_MUL = OP_BITS'(7);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t              state_q, state_d;
    logic [E_BITS-1:0]   acc_q [N_ACC];
    logic [E_BITS-1:0]   acc_d [N_ACC];
    logic [3:0]          flags_q, flags_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [E_BITS-1:0]   mcand_q, mcand_d;
    logic [E_BITS-1:0]   hi_q, hi_d;
    logic [E_BITS-1:0]   lo_q, lo_d;
    logic [AW-1:0]       tgt_q, tgt_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [E_BITS-1:0]   imm_ext, op_a, op_b, alu_r;
    logic                alu_c, alu_v;
    logic [SH_W-1:0]     sh_amt;
    logic [E_BITS:0]     add_w, shl_w, mul_sum;
    logic signed [E_BITS:0] sra_w;

    assign imm_ext    = E_BITS'($signed(i_Data));
    assign op_a       = acc_q[i_acc_sel];
    assign op_b       = sel_B ? i_Data_ram : imm_ext;
    assign sh_amt     = op_b[SH_W-1:0];
    assign o_Addr_ram = i_Data;
    assign o_Data_ram = acc_q[i_acc_sel];
    assign o_flags    = flags_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

    // Shifts carry an extra guard bit so the last bit shifted out lands in it.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        add_w = '0;
        shl_w = '0;
        sra_w = '0;
        case (i_op)
            OP_ADD: begin
                add_w = {1'b0, op_a} + {1'b0, op_b};
                alu_r = add_w[E_BITS-1:0];
                alu_c = add_w[E_BITS];
                alu_v = (op_a[MSB] == op_b[MSB]) && (alu_r[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_r = op_a - op_b;
                alu_c = (op_a >= op_b);
                alu_v = (op_a[MSB] != op_b[MSB]) && (alu_r[MSB] != op_a[MSB]);
            end
            OP_AND: alu_r = op_a & op_b;
            OP_OR:  alu_r = op_a | op_b;
            OP_XOR: alu_r = op_a ^ op_b;
            OP_SHL: begin
                shl_w = {1'b0, op_a} << sh_amt;
                alu_r = shl_w[E_BITS-1:0];
                alu_c = shl_w[E_BITS];
            end
            OP_SRA: begin
                sra_w = $signed({op_a, 1'b0}) >>> sh_amt;
                alu_r = sra_w[E_BITS:1];
                alu_c = sra_w[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        mul_sum = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_acc) begin
                    if (sel_A == S_BITS'(0)) begin
                        acc_d[i_acc_sel] = imm_ext;
                    end else if (sel_A == S_BITS'(1)) begin
                        acc_d[i_acc_sel] = i_Data_ram;
                    end else if (sel_A == S_BITS'(2)) begin
                        if (i_op == OP_MUL) begin
                            mcand_d = op_a;
                            hi_d    = '0;
                            lo_d    = op_b;
                            tgt_d   = i_acc_sel;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = ST_MUL;
                        end else begin
                            acc_d[i_acc_sel] = alu_r;
                            flags_d = {alu_r == '0, alu_r[MSB], alu_c, alu_v};
                        end
                    end
                end
            end
            ST_MUL: begin
                // {hi,lo} starts as {0,multiplier} and ends holding the full product.
                mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
                {hi_d, lo_d} = {mul_sum, lo_q[E_BITS-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(E_BITS - 1)) begin
                    acc_d[tgt_q] = lo_d;
                    flags_d = {lo_d == '0, lo_d[MSB], |hi_d, |hi_d};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_ACC; i++) begin
                acc_q[i] <= '0;
            end
            flags_q <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_datapath_multi.sv
// tb/tb_datapath_multi.sv - self-checking bench for datapath_multi against an arithmetic reference model
module tb_datapath_multi;
    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [10:0] i_Data;
    logic [15:0] i_Data_ram;
    logic [1:0]  sel_A;
    logic        sel_B;
    logic [2:0]  i_op;
    logic        w_acc;
    logic [1:0]  i_acc_sel;
    logic [10:0] o_Addr_ram;
    logic [15:0] o_Data_ram;
    logic [3:0]  o_flags;
    logic        o_busy;
    logic        o_done;

    int total = 0;
    int bad = 0;
    logic [15:0] m_acc [4];
    logic [3:0]  m_flags;

    datapath_multi dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_Data(i_Data), .i_Data_ram(i_Data_ram),
        .sel_A(sel_A), .sel_B(sel_B), .i_op(i_op), .w_acc(w_acc), .i_acc_sel(i_acc_sel),
        .o_Addr_ram(o_Addr_ram), .o_Data_ram(o_Data_ram), .o_flags(o_flags),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #10 i_clock = ~i_clock;

    function automatic logic [15:0] ext(input logic [10:0] d);
        int s;
        s = $signed(d);
        return s[15:0];
    endfunction

    // Returns {Z,N,C,V,result} computed with plain integer arithmetic.
    function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        longint ua, ub, r;
        int sa, sb, amt;
        logic c, v;
        logic [15:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); amt = b[3:0];
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
            3'd1: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 32767) || (sa - sb < -32768); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << amt; c = (amt != 0) && (((ua >> (16 - amt)) & 1) == 1); end
            3'd6: begin r = longint'(sa >>> amt); c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1); end
            default: begin r = ua * ub; c = ((r >> 16) != 0); v = c; end
        endcase
        res = r[15:0];
        return {res == 16'h0, res[15], c, v, res};
    endfunction

    task automatic model_apply(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                               input logic [1:0] idx, input logic [10:0] d, input logic [15:0] ram);
        logic [19:0] res;
        case (sa)
            2'd0: m_acc[idx] = ext(d);
            2'd1: m_acc[idx] = ram;
            2'd2: begin
                res = ref_alu(m_acc[idx], sb ? ram : ext(d), op);
                m_acc[idx] = res[15:0];
                m_flags = res[19:16];
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                         input logic [1:0] idx, input logic [10:0] d, input logic [15:0] ram);
        @(negedge i_clock);
        sel_A = sa; sel_B = sb; i_op = op; i_acc_sel = idx; i_Data = d; i_Data_ram = ram; w_acc = 1'b1;
        @(posedge i_clock);
        #1;
        w_acc = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_acc[k] = 16'h0;
        m_flags = 4'h0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; w_acc = 1'b0; sel_A = 0; sel_B = 0; i_op = 0; i_acc_sel = 0;
        i_Data = 0; i_Data_ram = 0;
        model_reset();
        repeat (3) @(posedge i_clock);
        #2;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
        total++; if (o_flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0", o_flags); end
        for (int k = 0; k < 4; k++) begin
            i_acc_sel = k[1:0]; #1;
            total++;
            if (o_Data_ram !== 16'h0) begin bad++; $display("FAIL reset_acc%0d got=%h exp=0", k, o_Data_ram); end
        end
        @(negedge i_clock);
        i_reset = 1'b1;
    endtask

    task automatic test_load_imm();
        model_apply(2'd0, 1'b0, 3'd0, 2'd0, 11'h7FF, 16'h0);
        drive(2'd0, 1'b0, 3'd0, 2'd0, 11'h7FF, 16'h0);
        total++; if (o_Data_ram !== 16'hFFFF) begin bad++; $display("FAIL load_imm got=%h exp=ffff", o_Data_ram); end
        total++; if (o_flags !== 4'h0) begin bad++; $display("FAIL load_imm_flags got=%h exp=0", o_flags); end
        total++; if (o_Addr_ram !== 11'h7FF) begin bad++; $display("FAIL addr_passthru got=%h exp=7ff", o_Addr_ram); end
    endtask

    task automatic test_add_sub();
        model_apply(2'd1, 1'b0, 3'd0, 2'd1, 11'h0, 16'h7FFF);
        drive(2'd1, 1'b0, 3'd0, 2'd1, 11'h0, 16'h7FFF);
        model_apply(2'd2, 1'b0, 3'd0, 2'd1, 11'h001, 16'h0);
        drive(2'd2, 1'b0, 3'd0, 2'd1, 11'h001, 16'h0);
        total++; if (o_Data_ram !== 16'h8000) begin bad++; $display("FAIL add_ovf got=%h exp=8000", o_Data_ram); end
        total++; if (o_flags !== 4'b0101) begin bad++; $display("FAIL add_flags got=%b exp=0101", o_flags); end
        model_apply(2'd0, 1'b0, 3'd0, 2'd2, 11'h005, 16'h0);
        drive(2'd0, 1'b0, 3'd0, 2'd2, 11'h005, 16'h0);
        model_apply(2'd2, 1'b1, 3'd1, 2'd2, 11'h0, 16'h0005);
        drive(2'd2, 1'b1, 3'd1, 2'd2, 11'h0, 16'h0005);
        total++; if (o_Data_ram !== 16'h0) begin bad++; $display("FAIL sub_zero got=%h exp=0", o_Data_ram); end
        total++; if (o_flags !== 4'b1010) begin bad++; $display("FAIL sub_flags got=%b exp=1010", o_flags); end
        for (int k = 0; k < 4; k++) begin
            i_acc_sel = k[1:0]; #1;
            total++;
            if (o_Data_ram !== m_acc[k]) begin bad++; $display("FAIL sub_others acc%0d got=%h exp=%h", k, o_Data_ram, m_acc[k]); end
        end
    endtask

    task automatic test_shift();
        model_apply(2'd1, 1'b0, 3'd0, 2'd3, 11'h0, 16'h8001);
        drive(2'd1, 1'b0, 3'd0, 2'd3, 11'h0, 16'h8001);
        model_apply(2'd2, 1'b0, 3'd6, 2'd3, 11'h001, 16'h0);
        drive(2'd2, 1'b0, 3'd6, 2'd3, 11'h001, 16'h0);
        total++; if (o_Data_ram !== 16'hC000) begin bad++; $display("FAIL sra1 got=%h exp=c000", o_Data_ram); end
        total++; if (o_flags !== 4'b0110) begin bad++; $display("FAIL sra1_flags got=%b exp=0110", o_flags); end
        model_apply(2'd2, 1'b0, 3'd5, 2'd3, 11'h000, 16'h0);
        drive(2'd2, 1'b0, 3'd5, 2'd3, 11'h000, 16'h0);
        total++; if (o_Data_ram !== 16'hC000) begin bad++; $display("FAIL shl0 got=%h exp=c000", o_Data_ram); end
        total++; if (o_flags !== 4'b0100) begin bad++; $display("FAIL shl0_flags got=%b exp=0100", o_flags); end
    endtask

    task automatic test_mul();
        int busy_cnt;
        busy_cnt = 0;
        model_apply(2'd0, 1'b0, 3'd0, 2'd0, 11'h123, 16'h0);
        drive(2'd0, 1'b0, 3'd0, 2'd0, 11'h123, 16'h0);
        model_apply(2'd2, 1'b0, 3'd7, 2'd0, 11'h010, 16'h0);
        drive(2'd2, 1'b0, 3'd7, 2'd0, 11'h010, 16'h0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!o_busy) break;
            busy_cnt++;
            if (cyc == 3) begin
                @(negedge i_clock);
                sel_A = 2'd0; i_Data = 11'h555; i_acc_sel = 2'd0; w_acc = 1'b1;
            end
            @(posedge i_clock);
            #1;
            w_acc = 1'b0;
        end
        total++; if (busy_cnt !== 16) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=16", busy_cnt); end
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL mul_done got=%b exp=1", o_done); end
        total++; if (o_Data_ram !== 16'h1230) begin bad++; $display("FAIL mul_result got=%h exp=1230", o_Data_ram); end
        total++; if (o_flags !== m_flags) begin bad++; $display("FAIL mul_flags got=%b exp=%b", o_flags, m_flags); end
        @(posedge i_clock);
        #1;
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b exp=0", o_done); end
    endtask

    task automatic test_reset_mul();
        int done_cnt, wait_cnt;
        done_cnt = 0;
        wait_cnt = 0;
        model_apply(2'd0, 1'b0, 3'd0, 2'd0, 11'h123, 16'h0);
        drive(2'd0, 1'b0, 3'd0, 2'd0, 11'h123, 16'h0);
        drive(2'd2, 1'b0, 3'd7, 2'd0, 11'h010, 16'h0);
        repeat (5) @(posedge i_clock);
        #3;
        i_reset = 1'b0;
        #1;
        model_reset();
        i_acc_sel = 2'd0;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmul_busy got=%b exp=0", o_busy); end
        total++; if (o_Data_ram !== 16'h0) begin bad++; $display("FAIL rstmul_acc got=%h exp=0", o_Data_ram); end
        @(negedge i_clock);
        i_reset = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge i_clock);
            #1;
            if (o_done || o_busy) done_cnt++;
        end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL rstmul_no_done got=%0d exp=0", done_cnt); end
        model_apply(2'd0, 1'b0, 3'd0, 2'd0, 11'h123, 16'h0);
        drive(2'd0, 1'b0, 3'd0, 2'd0, 11'h123, 16'h0);
        model_apply(2'd2, 1'b0, 3'd7, 2'd0, 11'h7FF, 16'h0);
        drive(2'd2, 1'b0, 3'd7, 2'd0, 11'h7FF, 16'h0);
        while (!o_done && wait_cnt < 40) begin
            @(posedge i_clock);
            #1;
            wait_cnt++;
        end
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL rstmul_next_done got=%b exp=1", o_done); end
        total++; if (o_Data_ram !== m_acc[0]) begin bad++; $display("FAIL rstmul_next_result got=%h exp=%h", o_Data_ram, m_acc[0]); end
        total++; if (o_flags !== m_flags) begin bad++; $display("FAIL rstmul_next_flags got=%b exp=%b", o_flags, m_flags); end
    endtask

    task automatic test_random();
        logic [1:0]  sa, idx;
        logic        sb;
        logic [2:0]  op;
        logic [10:0] d;
        logic [15:0] ram;
        int wait_cnt;
        for (int it = 0; it < 80; it++) begin
            sa = 2'($urandom_range(0, 3)); sb = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7)); idx = 2'($urandom_range(0, 3));
            d = 11'($urandom); ram = 16'($urandom);
            model_apply(sa, sb, op, idx, d, ram);
            drive(sa, sb, op, idx, d, ram);
            if (sa == 2'd2 && op == 3'd7) begin
                wait_cnt = 0;
                while (!o_done && wait_cnt < 40) begin
                    @(posedge i_clock);
                    #1;
                    wait_cnt++;
                end
                total++;
                if (o_done !== 1'b1) begin bad++; $display("FAIL rand_mul_done it=%0d got=%b exp=1", it, o_done); end
            end
            total++;
            if (o_flags !== m_flags) begin bad++; $display("FAIL rand_flags it=%0d op=%0d got=%b exp=%b", it, op, o_flags, m_flags); end
            for (int k = 0; k < 4; k++) begin
                i_acc_sel = k[1:0]; #1;
                total++;
                if (o_Data_ram !== m_acc[k]) begin
                    bad++;
                    $display("FAIL rand_acc it=%0d acc%0d sa=%0d op=%0d got=%h exp=%h", it, k, sa, op, o_Data_ram, m_acc[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_add_sub();
        test_shift();
        test_mul();
        test_reset_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
